// File: rtl/mux2to1_8bit_arb.sv
// Round-robin merge of two valid/ready word streams onto one registered output,
// tagging each word with its source and counting accepted words per source.
module mux2to1_8bit_arb #(
    parameter int   WIDTH     = 8,
    parameter logic PRIO_INIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic             A_valid,
    output logic             A_ready,
    input  logic [WIDTH-1:0] B,
    input  logic             B_valid,
    output logic             B_ready,
    output logic [WIDTH-1:0] OUT,
    output logic             OUT_valid,
    input  logic             OUT_ready,
    output logic             OUT_sel,
    output logic [7:0]       CNT_A,
    output logic [7:0]       CNT_B
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] data_reg, data_next;
    logic             sel_reg, sel_next;
    logic             pri_reg, pri_next;
    logic             load_en;
    logic [1:0]       xfer;

    // Grants look only at the other source's valid, so no path runs from a
    // producer's valid back to its own ready.
    assign load_en = (state_reg == EMPTY) | OUT_ready;
    assign A_ready = load_en & (~B_valid | (pri_reg == 1'b0));
    assign B_ready = load_en & (~A_valid | (pri_reg == 1'b1));
    assign xfer[0] = A_valid & A_ready;
    assign xfer[1] = B_valid & B_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= EMPTY;
            data_reg  <= '0;
            sel_reg   <= 1'b0;
            pri_reg   <= PRIO_INIT;
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
            sel_reg   <= sel_next;
            pri_reg   <= pri_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        sel_next   = sel_reg;
        pri_next   = pri_reg;
        if (xfer[0]) begin
            state_next = FULL;
            data_next  = A;
            sel_next   = 1'b0;
            pri_next   = 1'b1;
        end else if (xfer[1]) begin
            state_next = FULL;
            data_next  = B;
            sel_next   = 1'b1;
            pri_next   = 1'b0;
        end else if ((state_reg == FULL) && OUT_ready) begin
            // Drain only: data and source tag are left as they were.
            state_next = EMPTY;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [7:0] cnt_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= 8'd0;
                end else if (xfer[gi]) begin
                    cnt_reg <= cnt_reg + 8'd1;
                end
            end
        end
    endgenerate

    assign OUT       = data_reg;
    assign OUT_valid = (state_reg == FULL);
    assign OUT_sel   = sel_reg;
    assign CNT_A     = g_cnt[0].cnt_reg;
    assign CNT_B     = g_cnt[1].cnt_reg;

endmodule
